// File: rtl/if_id_ctrl_if.sv
// IF/ID controller bundle: fetch, decode and EX-side signals.
// master drives the inputs, slave is the controller itself.
interface if_id_ctrl_if;
    logic [31:0] ins_i;
    logic [31:0] ins_addr_i;
    logic        ins_valid_i;
    logic        hold_i;
    logic [4:0]  dec_rs1_i;
    logic [4:0]  dec_rs2_i;
    logic        ex_load_i;
    logic [4:0]  ex_rd_i;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic [31:0] ins_o;
    logic [31:0] ins_addr_o;
    logic        ins_valid_o;
    logic        pc_hold_o;
    logic        pc_we_o;
    logic [31:0] pc_wdata_o;
    logic        bubble_o;
    logic [1:0]  state_o;

    modport master (
        output ins_i, ins_addr_i, ins_valid_i,
        output hold_i, dec_rs1_i, dec_rs2_i,
        output ex_load_i, ex_rd_i,
        output jump_en_i, jump_addr_i,
        input  ins_o, ins_addr_o, ins_valid_o,
        input  pc_hold_o, pc_we_o, pc_wdata_o,
        input  bubble_o, state_o
    );

    modport slave (
        input  ins_i, ins_addr_i, ins_valid_i,
        input  hold_i, dec_rs1_i, dec_rs2_i,
        input  ex_load_i, ex_rd_i,
        input  jump_en_i, jump_addr_i,
        output ins_o, ins_addr_o, ins_valid_o,
        output pc_hold_o, pc_we_o, pc_wdata_o,
        output bubble_o, state_o
    );
endinterface

// File: rtl/if_id_ctrl.sv
// IF/ID register with load-use/hold stalls and jump flush.
// Define LOAD_USE_STALL_EN to enable load-use hazard stalls.
module if_id_ctrl #(
    parameter logic [31:0] NOP_INS      = 32'h0000_0013,
    parameter logic [31:0] RESET_ADDR   = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input logic         clk,
    input logic         rst_n,
    if_id_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [3:0] FC = 4'(FLUSH_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] ins_q, ins_d;
    logic [31:0] addr_q, addr_d;
    logic        vld_q, vld_d;
    logic        hazard;
    logic        stall;
    logic        jump;

`ifdef LOAD_USE_STALL_EN
    assign hazard = bus.ex_load_i
                  & (bus.ex_rd_i != 5'd0)
                  & vld_q
                  & ((bus.ex_rd_i == bus.dec_rs1_i)
                   | (bus.ex_rd_i == bus.dec_rs2_i));
`else
    logic unused_ok;
    assign unused_ok = ^{bus.ex_load_i, bus.ex_rd_i,
                         bus.dec_rs1_i, bus.dec_rs2_i};
    assign hazard = 1'b0;
`endif

    assign jump  = bus.jump_en_i;
    assign stall = bus.hold_i | hazard;

    assign bus.pc_we_o     = jump;
    assign bus.pc_wdata_o  = bus.jump_addr_i;
    assign bus.pc_hold_o   = stall & ~jump;
    assign bus.bubble_o    = (state_q == FLUSH) | stall | jump;
    assign bus.ins_o       = ins_q;
    assign bus.ins_addr_o  = addr_q;
    assign bus.ins_valid_o = vld_q;
    assign bus.state_o     = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ins_d   = ins_q;
        addr_d  = addr_q;
        vld_d   = vld_q;
        unique case (state_q)
            RUN, STALL: begin
                if (jump) begin
                    ins_d   = NOP_INS;
                    vld_d   = 1'b0;
                    cnt_d   = FC;
                    state_d = FLUSH;
                end else if (stall) begin
                    state_d = STALL;
                end else begin
                    state_d = RUN;
                    if (bus.ins_valid_i) begin
                        ins_d  = bus.ins_i;
                        addr_d = bus.ins_addr_i;
                        vld_d  = 1'b1;
                    end else begin
                        ins_d = NOP_INS;
                        vld_d = 1'b0;
                    end
                end
            end
            FLUSH: begin
                ins_d = NOP_INS;
                vld_d = 1'b0;
                if (jump) begin
                    cnt_d = FC;
                end else if (!bus.hold_i) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
            ins_q   <= NOP_INS;
            addr_q  <= RESET_ADDR;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ins_q   <= ins_d;
            addr_q  <= addr_d;
            vld_q   <= vld_d;
        end
    end
endmodule

// File: tb/tb_if_id_ctrl.sv
// Randomized bench for if_id_ctrl against a queue-free behavioural model.
// Directed cases pin reset, straight-line, load-use and flush timing.
module tb_if_id_ctrl;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int F = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    if_id_ctrl_if bus ();

    if_id_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // model: IF/ID contents, flush cycles remaining, stalled flag
    logic [31:0] m_ins;
    logic [31:0] m_addr;
    bit          m_vld;
    int          m_left;
    bit          m_stalled;

    function automatic bit m_hazard();
`ifdef LOAD_USE_STALL_EN
        return bus.ex_load_i && bus.ex_rd_i != 0 && m_vld &&
               (bus.ex_rd_i == bus.dec_rs1_i ||
                bus.ex_rd_i == bus.dec_rs2_i);
`else
        return 1'b0;
`endif
    endfunction

    task automatic m_reset();
        m_ins = NOP;
        m_addr = 32'h0;
        m_vld = 0;
        m_left = 0;
        m_stalled = 0;
    endtask

    task automatic m_edge();
        bit st;
        st = bus.hold_i || m_hazard();
        if (bus.jump_en_i) begin
            m_ins = NOP;
            m_vld = 0;
            m_left = F;
            m_stalled = 0;
        end else if (m_left > 0) begin
            m_ins = NOP;
            m_vld = 0;
            if (!bus.hold_i) m_left--;
        end else if (st) begin
            m_stalled = 1;
        end else begin
            m_stalled = 0;
            if (bus.ins_valid_i) begin
                m_ins = bus.ins_i;
                m_addr = bus.ins_addr_i;
                m_vld = 1;
            end else begin
                m_ins = NOP;
                m_vld = 0;
            end
        end
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    task automatic check_all();
        bit st;
        bit [1:0] es;
        st = bus.hold_i || m_hazard();
        es = (m_left > 0) ? 2'd2 : (m_stalled ? 2'd1 : 2'd0);
        chk("ins_o", bus.ins_o, m_ins);
        chk("ins_addr_o", bus.ins_addr_o, m_addr);
        chk("ins_valid_o", 32'(bus.ins_valid_o), 32'(m_vld));
        chk("state_o", 32'(bus.state_o), 32'(es));
        chk("pc_we_o", 32'(bus.pc_we_o), 32'(bus.jump_en_i));
        chk("pc_wdata_o", bus.pc_wdata_o, bus.jump_addr_i);
        chk("pc_hold_o", 32'(bus.pc_hold_o),
            32'(st && !bus.jump_en_i));
        chk("bubble_o", 32'(bus.bubble_o),
            32'(m_left > 0 || st || bus.jump_en_i));
    endtask

    // settle, compare, clock once, advance model
    task automatic cyc();
        #1;
        check_all();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic idle();
        bus.ins_i = NOP;
        bus.ins_addr_i = 32'h0;
        bus.ins_valid_i = 0;
        bus.hold_i = 0;
        bus.dec_rs1_i = 0;
        bus.dec_rs2_i = 0;
        bus.ex_load_i = 0;
        bus.ex_rd_i = 0;
        bus.jump_en_i = 0;
        bus.jump_addr_i = 32'h0;
    endtask

    initial begin
        idle();
        m_reset();
        #12;
        chk("rst ins_o", bus.ins_o, 32'h13);
        chk("rst addr", bus.ins_addr_o, 32'h0);
        chk("rst valid", 32'(bus.ins_valid_o), 32'd0);
        chk("rst state", 32'(bus.state_o), 32'd0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // straight line
        bus.ins_i = 32'h0050_0093;
        bus.ins_addr_i = 32'h0;
        bus.ins_valid_i = 1;
        cyc();
        chk("sl ins0", bus.ins_o, 32'h0050_0093);
        chk("sl vld0", 32'(bus.ins_valid_o), 32'd1);
        bus.ins_i = 32'h0010_8113;
        bus.ins_addr_i = 32'h4;
        cyc();
        chk("sl ins1", bus.ins_o, 32'h0010_8113);
        chk("sl addr1", bus.ins_addr_o, 32'h4);
        chk("sl hold", 32'(bus.pc_hold_o), 32'd0);
        chk("sl bubble", 32'(bus.bubble_o), 32'd0);

        // load-use on add x3,x1,x2
        bus.ins_i = 32'h0020_81b3;
        bus.ins_addr_i = 32'h8;
        cyc();
        bus.ins_valid_i = 0;
        bus.dec_rs1_i = 5'd1;
        bus.dec_rs2_i = 5'd2;
        bus.ex_load_i = 1;
        bus.ex_rd_i = 5'd1;
        #1;
`ifdef LOAD_USE_STALL_EN
        chk("lu hold", 32'(bus.pc_hold_o), 32'd1);
        chk("lu bubble", 32'(bus.bubble_o), 32'd1);
`else
        chk("lu off hold", 32'(bus.pc_hold_o), 32'd0);
        chk("lu off bubble", 32'(bus.bubble_o), 32'd0);
`endif
        cyc();
`ifdef LOAD_USE_STALL_EN
        chk("lu ins kept", bus.ins_o, 32'h0020_81b3);
`endif
        bus.ex_load_i = 0;
        bus.ex_rd_i = 5'd0;
        #1;
        chk("lu gone", 32'(bus.pc_hold_o), 32'd0);
        bus.ex_load_i = 1;
        #1;
        chk("lu rd0", 32'(bus.pc_hold_o), 32'd0);
        bus.ex_load_i = 0;
        cyc();

        // jump in RUN: three invalid cycles, then target
        bus.jump_en_i = 1;
        bus.jump_addr_i = 32'h100;
        #1;
        chk("j we", 32'(bus.pc_we_o), 32'd1);
        chk("j wdata", bus.pc_wdata_o, 32'h100);
        cyc();
        bus.jump_en_i = 0;
        bus.ins_i = 32'h0000_0513;
        bus.ins_addr_i = 32'h100;
        bus.ins_valid_i = 1;
        chk("j v1", 32'(bus.ins_valid_o), 32'd0);
        chk("j st1", 32'(bus.state_o), 32'd2);
        cyc();
        chk("j v2", 32'(bus.ins_valid_o), 32'd0);
        cyc();
        chk("j v3", 32'(bus.ins_valid_o), 32'd0);
        chk("j st3", 32'(bus.state_o), 32'd0);
        cyc();
        chk("j v4", 32'(bus.ins_valid_o), 32'd1);
        chk("j addr4", bus.ins_addr_o, 32'h100);

        // jump under hold, then hold for 4 cycles in FLUSH
        bus.hold_i = 1;
        cyc();
        chk("jh stall", 32'(bus.state_o), 32'd1);
        bus.jump_en_i = 1;
        bus.jump_addr_i = 32'h200;
        #1;
        chk("jh hold", 32'(bus.pc_hold_o), 32'd0);
        chk("jh we", 32'(bus.pc_we_o), 32'd1);
        cyc();
        bus.jump_en_i = 0;
        for (int i = 0; i < 4; i++) cyc();
        bus.hold_i = 0;
        cyc();
        chk("jh st5", 32'(bus.state_o), 32'd2);
        cyc();
        chk("jh st6", 32'(bus.state_o), 32'd0);
        cyc();
        chk("jh v7", 32'(bus.ins_valid_o), 32'd1);

        // back-to-back jumps, then reset mid-flush
        bus.jump_en_i = 1;
        cyc();
        cyc();
        bus.jump_en_i = 0;
        cyc();
        chk("bb v", 32'(bus.ins_valid_o), 32'd0);
        chk("bb st", 32'(bus.state_o), 32'd2);
        #2;
        rst_n = 0;
        #1;
        m_reset();
        chk("mr state", 32'(bus.state_o), 32'd0);
        chk("mr ins", bus.ins_o, 32'h13);
        chk("mr addr", bus.ins_addr_o, 32'h0);
        chk("mr valid", 32'(bus.ins_valid_o), 32'd0);
        @(negedge clk);
        rst_n = 1;
        #1;

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            bus.ins_i = $urandom;
            bus.ins_addr_i = $urandom & 32'hffff_fffc;
            bus.ins_valid_i = ($urandom_range(3) != 0);
            bus.hold_i = ($urandom_range(5) == 0);
            bus.dec_rs1_i = 5'($urandom_range(3));
            bus.dec_rs2_i = 5'($urandom_range(3));
            bus.ex_load_i = ($urandom_range(2) == 0);
            bus.ex_rd_i = 5'($urandom_range(3));
            bus.jump_en_i = ($urandom_range(11) == 0);
            bus.jump_addr_i = $urandom & 32'hffff_fffc;
            cyc();
        end
        #1;
        check_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
